ascon_permutation_iter: RTL and testbench

ASCON_PERMUTATION_ITER -- requirements
Module: ascon_permutation_iter

---
 rtl/ascon_permutation_iter.sv | 163 ++++++++++++++++
 tb/tb_ascon_permutation_iter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ascon_permutation_iter.sv
// Iterative Ascon permutation: UNROLL rounds per clock, up to MAX_ROUNDS rounds per request.
// Word i of every state vector holds Ascon word xi (x0 at index 0).
module ascon_permutation_iter #(
  parameter int UNROLL     = 1,
  parameter int MAX_ROUNDS = 12
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic [3:0]       nb_rounds_i,
  input  logic [4:0][63:0] state_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [4:0][63:0] state_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [4:0] LAST_ROUND = 5'(MAX_ROUNDS - 1);

  logic [1:0]       fsm_d, fsm_q;
  logic [3:0]       round_d, round_q;
  logic [4:0][63:0] work_d, work_q;
  logic [4:0][63:0] result_d, result_q;
  logic             valid_d, valid_q;
  logic [3:0]       n_clamped_s;
  logic [4:0]       next_round_s;
  logic [4:0][63:0] round_out_s;

  function automatic logic [4:0] sbox(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'd0:  y = 5'h04;  5'd1:  y = 5'h0B;  5'd2:  y = 5'h1F;  5'd3:  y = 5'h14;
      5'd4:  y = 5'h1A;  5'd5:  y = 5'h15;  5'd6:  y = 5'h09;  5'd7:  y = 5'h02;
      5'd8:  y = 5'h1B;  5'd9:  y = 5'h05;  5'd10: y = 5'h08;  5'd11: y = 5'h12;
      5'd12: y = 5'h1D;  5'd13: y = 5'h03;  5'd14: y = 5'h06;  5'd15: y = 5'h1C;
      5'd16: y = 5'h1E;  5'd17: y = 5'h13;  5'd18: y = 5'h07;  5'd19: y = 5'h0E;
      5'd20: y = 5'h00;  5'd21: y = 5'h0D;  5'd22: y = 5'h11;  5'd23: y = 5'h18;
      5'd24: y = 5'h10;  5'd25: y = 5'h0C;  5'd26: y = 5'h01;  5'd27: y = 5'h19;
      5'd28: y = 5'h16;  5'd29: y = 5'h0A;  5'd30: y = 5'h0F;  5'd31: y = 5'h17;
      default: y = 5'h00;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int a);
    return (x >> a) | (x << (64 - a));
  endfunction

  function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s,
                                                   input logic [3:0] r);
    logic [4:0][63:0] c;
    logic [4:0][63:0] t;
    logic [4:0][63:0] o;
    logic [4:0]       col;
    c = s;
    c[2][7:0] = c[2][7:0] ^ {4'hF - r, r};
    t = '0;
    for (int i = 0; i < 64; i++) begin
      col = sbox({c[0][i], c[1][i], c[2][i], c[3][i], c[4][i]});
      t[0][i] = col[4];
      t[1][i] = col[3];
      t[2][i] = col[2];
      t[3][i] = col[1];
      t[4][i] = col[0];
    end
    o[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
    o[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
    o[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
    o[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
    o[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
    return o;
  endfunction

  // Stages whose round index runs past the last round forward the state untouched.
  function automatic logic [4:0][63:0] run_stages(input logic [4:0][63:0] s,
                                                  input logic [3:0] r0);
    logic [4:0][63:0] acc;
    logic [4:0]       idx;
    acc = s;
    for (int k = 0; k < UNROLL; k++) begin
      idx = 5'(r0) + 5'(k);
      if (idx <= LAST_ROUND) begin
        acc = ascon_round(acc, idx[3:0]);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  // Next-state logic for the control FSM, round counter and data registers.
  always_comb begin
    n_clamped_s  = (nb_rounds_i > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : nb_rounds_i;
    round_out_s  = run_stages(work_q, round_q);
    next_round_s = 5'(round_q) + 5'(UNROLL);
    fsm_d    = fsm_q;
    round_d  = round_q;
    work_d   = work_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          work_d = state_i;
          if (n_clamped_s == 4'd0) begin
            fsm_d    = DONE;
            result_d = state_i;
            valid_d  = 1'b1;
            round_d  = 4'd0;
          end else begin
            fsm_d   = RUN;
            round_d = 4'(MAX_ROUNDS) - n_clamped_s;
          end
        end else begin
          fsm_d = IDLE;
        end
      end
      RUN: begin
        work_d = round_out_s;
        if (next_round_s > LAST_ROUND) begin
          fsm_d    = DONE;
          result_d = round_out_s;
          valid_d  = 1'b1;
          round_d  = 4'd0;
        end else begin
          fsm_d   = RUN;
          round_d = next_round_s[3:0];
        end
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d   = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  // State registers; reset abandons any permutation in flight.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q    <= IDLE;
      round_q  <= 4'd0;
      work_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      round_q  <= round_d;
      work_q   <= work_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_o = (fsm_q == IDLE);
  assign valid_o = valid_q;
  assign state_o = result_q;

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Randomized bench: three instances (UNROLL 1, 3, 4) share stimulus and are checked
// against a plain bitsliced Ascon model for result, latency, pulse count and hold.
module tb_ascon_permutation_iter;
  typedef logic [4:0][63:0] state_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   start = 1'b0;
  logic [3:0] nb = 4'd0;
  state_t st_in = '0;
  logic   ready [3];
  logic   valid [3];
  state_t st_out [3];
  state_t prev [3];
  int     unroll_tab [3] = '{1, 3, 4};
  int     checks = 0;
  int     failures = 0;

  always #5 clk = ~clk;

  ascon_permutation_iter #(.UNROLL(1)) u_dut_u1 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .nb_rounds_i(nb), .state_i(st_in),
    .ready_o(ready[0]), .valid_o(valid[0]), .state_o(st_out[0]));
  ascon_permutation_iter #(.UNROLL(3)) u_dut_u3 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .nb_rounds_i(nb), .state_i(st_in),
    .ready_o(ready[1]), .valid_o(valid[1]), .state_o(st_out[1]));
  ascon_permutation_iter #(.UNROLL(4)) u_dut_u4 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .nb_rounds_i(nb), .state_i(st_in),
    .ready_o(ready[2]), .valid_o(valid[2]), .state_o(st_out[2]));

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int a);
    return (x >> a) | (x << (64 - a));
  endfunction

  // Reference round written as the Ascon C model's bitsliced S-box expression.
  function automatic state_t ref_round(input state_t s, input int r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 = x2 ^ 64'(((15 - r) << 4) | r);
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  function automatic int eff_rounds(input int n);
    return (n > 12) ? 12 : n;
  endfunction

  function automatic state_t ref_perm(input state_t s, input int n);
    state_t a = s;
    for (int r = 12 - eff_rounds(n); r < 12; r++) a = ref_round(a, r);
    return a;
  endfunction

  function automatic int exp_latency(input int n, input int u);
    return (eff_rounds(n) + u - 1) / u + 1;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
    return s;
  endfunction

  // One request; inputs are scrambled after accept and an optional stray start hits RUN.
  task automatic run_req(input int n, input state_t s, input bit glitch, input string tag);
    int     lat [3];
    int     cnt [3];
    bit     moved [3];
    state_t got [3];
    state_t expst;
    expst = ref_perm(s, n);
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1; cnt[i] = 0; moved[i] = 1'b0; got[i] = '0;
    end
    start = 1'b1; nb = 4'(n); st_in = s;
    @(posedge clk); #1;
    start = 1'b0; nb = 4'($urandom_range(0, 15)); st_in = rand_state();
    for (int c = 1; c <= 20; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (valid[i]) begin
          cnt[i]++;
          if (lat[i] < 0) begin
            lat[i] = c;
            got[i] = st_out[i];
          end
        end else if (lat[i] < 0 && st_out[i] !== prev[i]) begin
          moved[i] = 1'b1;
        end
      end
      if (c == 1) check($sformatf("%s_busy", tag), {ready[0], ready[1], ready[2]}, 3'b000);
      start = glitch && (c == 2);
      if (start) st_in = rand_state();
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_u%0d_state", tag, unroll_tab[i]), got[i], expst);
      check($sformatf("%s_u%0d_lat", tag, unroll_tab[i]), lat[i], exp_latency(n, unroll_tab[i]));
      check($sformatf("%s_u%0d_pulses", tag, unroll_tab[i]), cnt[i], 1);
      check($sformatf("%s_u%0d_hold", tag, unroll_tab[i]), moved[i], 1'b0);
      check($sformatf("%s_u%0d_ready", tag, unroll_tab[i]), ready[i], 1'b1);
      prev[i] = expst;
    end
  endtask

  task automatic back_to_back();
    state_t s;
    int     first [3];
    int     second [3];
    s = rand_state();
    for (int i = 0; i < 3; i++) begin first[i] = -1; second[i] = -1; end
    start = 1'b1; nb = 4'd2; st_in = s;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 12) start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (valid[i] && first[i] < 0) first[i] = c;
        else if (valid[i] && second[i] < 0) second[i] = c;
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_u%0d_first", unroll_tab[i]), first[i], exp_latency(2, unroll_tab[i]));
      check($sformatf("b2b_u%0d_gap", unroll_tab[i]), second[i] - first[i],
            exp_latency(2, unroll_tab[i]) + 1);
      check($sformatf("b2b_u%0d_state", unroll_tab[i]), st_out[i], ref_perm(s, 2));
      prev[i] = ref_perm(s, 2);
    end
  endtask

  // Reset during the fifth RUN cycle of the UNROLL=1 instance, then an n=1 request.
  task automatic reset_mid_run();
    int pulses = 0;
    start = 1'b1; nb = 4'd12; st_in = rand_state();
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 5; c++) begin
      if (valid[0]) pulses++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_u%0d_state", unroll_tab[i]), st_out[i], '0);
      check($sformatf("rst_u%0d_valid", unroll_tab[i]), valid[i], 1'b0);
      check($sformatf("rst_u%0d_ready", unroll_tab[i]), ready[i], 1'b1);
      prev[i] = '0;
    end
    @(posedge clk); #1;
    if (valid[0]) pulses++;
    rst_n = 1'b1;
    check("rst_no_pulse", pulses, 0);
    run_req(1, rand_state(), 1'b0, "after_rst");
  endtask

  initial begin
    state_t init_s;
    state_t s;
    int n;
    for (int i = 0; i < 3; i++) prev[i] = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_u%0d_ready", unroll_tab[i]), ready[i], 1'b1);
      check($sformatf("reset_u%0d_valid", unroll_tab[i]), valid[i], 1'b0);
      check($sformatf("reset_u%0d_state", unroll_tab[i]), st_out[i], '0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    init_s[0] = 64'h80400C0600000000;
    init_s[1] = 64'h0001020304050607;
    init_s[2] = 64'h08090A0B0C0D0E0F;
    init_s[3] = 64'h0001020304050607;
    init_s[4] = 64'h08090A0B0C0D0E0F;
    run_req(12, init_s, 1'b0, "init12");
    run_req(6, rand_state(), 1'b0, "n6");
    run_req(8, rand_state(), 1'b0, "n8");
    run_req(0, rand_state(), 1'b0, "n0");
    s = rand_state();
    run_req(15, s, 1'b0, "n15");
    run_req(12, s, 1'b0, "n12_same");
    run_req(12, rand_state(), 1'b1, "stray_start");
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(0, 15);
      run_req(n, rand_state(), 1'b0, $sformatf("rand%0d", k));
    end
    back_to_back();
    reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
